// File: rtl/aip_hub_pkg.sv
// Shared definitions for the AIP slave hub: hub register codes, STATUS layout, select width.
// The hub codes occupy the top four values of the conf space; the low two bits pick the register.
package aip_hub_pkg;

  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    HUB_SEL      = 2'd0,
    HUB_INT_PEND = 2'd1,
    HUB_INT_MASK = 2'd2,
    HUB_STATUS   = 2'd3
  } hub_reg_e;

  localparam int ST_BUSY_LSB = 0;
  localparam int ST_NSL_LSB  = 8;
  localparam int ST_SEL_LSB  = 16;
  localparam int ST_ERR_BIT  = 20;
  localparam int ST_TO_BIT   = 21;

  // First hub code for a conf bus of the given width (2**w - 4).
  function automatic int hub_base(input int conf_width);
    return (1 << conf_width) - 4;
  endfunction

  function automatic logic [31:0] pack_status(input logic [7:0]       busy,
                                              input logic [7:0]       n_slaves,
                                              input logic [SEL_W-1:0] sel,
                                              input logic             err,
                                              input logic             to_any);
    logic [31:0] st;
    st = '0;
    st[ST_BUSY_LSB +: 8]    = busy;
    st[ST_NSL_LSB  +: 8]    = n_slaves;
    st[ST_SEL_LSB  +: SEL_W] = sel;
    st[ST_ERR_BIT]          = err;
    st[ST_TO_BIT]           = to_any;
    return st;
  endfunction

endpackage

// File: rtl/aip_hub_channel.sv
// One slave channel of the AIP hub: interrupt edge detect, busy, pending bit and,
// when AIP_HUB_TIMEOUT_EN is defined, a start-to-interrupt watchdog counter.
module aip_hub_channel
  import aip_hub_pkg::*;
#(
  parameter int TO_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_a_n,
  input  logic i_int,
  input  logic i_start,
  input  logic i_w1c,
  output logic o_busy,
  output logic o_pending,
  output logic o_to_flag
);

  logic r_int_q;
  logic r_busy;
  logic r_pending;
  logic w_edge;
  logic w_timeout;

  assign w_edge = i_int & ~r_int_q;

`ifdef AIP_HUB_TIMEOUT_EN
  localparam int CNT_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_to_flag;

  // A fresh start in the expiry cycle restarts the job instead of timing it out.
  assign w_timeout = r_busy & ~w_edge & ~i_start & (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_cnt     <= '0;
      r_to_flag <= 1'b0;
    end else begin
      if (i_start)
        r_cnt <= '0;
      else if (r_busy)
        r_cnt <= r_cnt + 1'b1;

      if (w_timeout)
        r_to_flag <= 1'b1;
      else if (i_w1c)
        r_to_flag <= 1'b0;
    end
  end

  assign o_to_flag = r_to_flag;
`else
  logic [31:0] w_unused_to_cycles;
  assign w_unused_to_cycles = 32'(TO_CYCLES);
  assign w_timeout          = 1'b0;
  assign o_to_flag          = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_int_q   <= 1'b0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_int_q <= i_int;

      if (i_start)
        r_busy <= 1'b1;
      else if (w_edge | w_timeout)
        r_busy <= 1'b0;

      // Set has priority over a same-cycle write-1-to-clear.
      if (w_edge | w_timeout)
        r_pending <= 1'b1;
      else if (i_w1c)
        r_pending <= 1'b0;
    end
  end

  assign o_busy    = r_busy;
  assign o_pending = r_pending;

endmodule

// File: rtl/aip_slave_hub.sv
// N-channel AIP slave hub: routes master strobes to the selected slave, muxes read data,
// and owns select, mask, error and interrupt request. Optional watchdog: AIP_HUB_TIMEOUT_EN.
module aip_slave_hub
  import aip_hub_pkg::*;
#(
  parameter int N_SLAVES   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CONF_WIDTH = 5,
  parameter int TO_CYCLES  = 1024
) (
  input  logic                           clk,
  input  logic                           rst_a_n,
  input  logic [DATA_WIDTH-1:0]          i_data_in,
  output logic [DATA_WIDTH-1:0]          o_data_out,
  input  logic [CONF_WIDTH-1:0]          i_conf,
  input  logic                           i_write,
  input  logic                           i_read,
  input  logic                           i_start,
  output logic                           o_int_req,
  output logic [N_SLAVES*DATA_WIDTH-1:0] o_data_in_s,
  output logic [N_SLAVES*CONF_WIDTH-1:0] o_conf_s,
  output logic [N_SLAVES-1:0]            o_write_s,
  output logic [N_SLAVES-1:0]            o_read_s,
  output logic [N_SLAVES-1:0]            o_start_s,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] i_data_out_s,
  input  logic [N_SLAVES-1:0]            i_int_s
);

  localparam logic [CONF_WIDTH-1:0] HUB_BASE = CONF_WIDTH'(hub_base(CONF_WIDTH));

  logic [SEL_W-1:0]      r_sel;
  logic [N_SLAVES-1:0]   r_mask;
  logic                  r_err;
  logic                  r_int_req;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic                  w_is_hub;
  hub_reg_e              w_hub_reg;
  logic                  w_hub_wr;
  logic                  w_sel_ok;
  logic [N_SLAVES-1:0]   w_busy;
  logic [N_SLAVES-1:0]   w_pending;
  logic [N_SLAVES-1:0]   w_to_flag;
  logic [N_SLAVES-1:0]   w_w1c;
  logic [7:0]            w_busy8;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_is_hub  = (i_conf >= HUB_BASE);
  assign w_hub_reg = hub_reg_e'(i_conf[1:0]);
  assign w_hub_wr  = i_write & w_is_hub;
  assign w_sel_ok  = ({1'b0, i_data_in[SEL_W-1:0]} < (SEL_W + 1)'(N_SLAVES));
  assign w_w1c     = (w_hub_wr && w_hub_reg == HUB_INT_PEND) ? i_data_in[N_SLAVES-1:0] : '0;

  assign o_conf_s    = {N_SLAVES{i_conf}};
  assign o_data_in_s = {N_SLAVES{i_data_in}};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    o_write_s = '0;
    o_read_s  = '0;
    o_start_s = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (r_sel == SEL_W'(k)) begin
        o_write_s[k] = i_write & ~w_is_hub;
        o_read_s[k]  = i_read & ~w_is_hub;
        o_start_s[k] = i_start;
      end
    end
  end

  for (genvar k = 0; k < N_SLAVES; k++) begin : g_ch
    aip_hub_channel #(
      .TO_CYCLES (TO_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_a_n   (rst_a_n),
      .i_int     (i_int_s[k]),
      .i_start   (o_start_s[k]),
      .i_w1c     (w_w1c[k]),
      .o_busy    (w_busy[k]),
      .o_pending (w_pending[k]),
      .o_to_flag (w_to_flag[k])
    );
  end

  always_comb begin
    w_busy8 = '0;
    for (int k = 0; k < N_SLAVES && k < 8; k++)
      w_busy8[k] = w_busy[k];
  end

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (r_sel == SEL_W'(k))
        w_rd_data = i_data_out_s[k*DATA_WIDTH +: DATA_WIDTH];
    end
    if (w_is_hub) begin
      unique case (w_hub_reg)
        HUB_SEL:      w_rd_data = DATA_WIDTH'(r_sel);
        HUB_INT_PEND: w_rd_data = DATA_WIDTH'(w_pending);
        HUB_INT_MASK: w_rd_data = DATA_WIDTH'(r_mask);
        HUB_STATUS:   w_rd_data = DATA_WIDTH'(pack_status(w_busy8, 8'(N_SLAVES), r_sel,
                                                          r_err, |w_to_flag));
      endcase
    end
  end

  // Select changes take effect next cycle, so a same-cycle start still targets the old slave.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      r_sel      <= '0;
      r_mask     <= '0;
      r_err      <= 1'b0;
      r_int_req  <= 1'b0;
      r_data_out <= '0;
    end else begin
      if (w_hub_wr) begin
        unique case (w_hub_reg)
          HUB_SEL: begin
            if (w_sel_ok)
              r_sel <= i_data_in[SEL_W-1:0];
            else
              r_err <= 1'b1;
          end
          HUB_INT_MASK: r_mask <= i_data_in[N_SLAVES-1:0];
          HUB_STATUS:   r_err  <= 1'b0;
          HUB_INT_PEND: ;
        endcase
      end
      r_int_req <= |(w_pending & r_mask);
      if (i_read)
        r_data_out <= w_rd_data;
    end
  end

  assign o_int_req  = r_int_req;
  assign o_data_out = r_data_out;

endmodule

// File: tb/tb_aip_slave_hub.sv
// Directed self-checking bench for aip_slave_hub (4 slaves, 32-bit data, 5-bit conf, 16-cycle watchdog).
// Expected values are hand-derived; the watchdog scenario expects different results with AIP_HUB_TIMEOUT_EN.
module tb_aip_slave_hub;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 5;
  localparam logic [CW-1:0] C_SEL    = 5'h1C;
  localparam logic [CW-1:0] C_PEND   = 5'h1D;
  localparam logic [CW-1:0] C_MASK   = 5'h1E;
  localparam logic [CW-1:0] C_STATUS = 5'h1F;

  logic            clk = 1'b0;
  logic            rst_a_n;
  logic [DW-1:0]   i_data_in;
  logic [DW-1:0]   o_data_out;
  logic [CW-1:0]   i_conf;
  logic            i_write;
  logic            i_read;
  logic            i_start;
  logic            o_int_req;
  logic [N*DW-1:0] o_data_in_s;
  logic [N*CW-1:0] o_conf_s;
  logic [N-1:0]    o_write_s;
  logic [N-1:0]    o_read_s;
  logic [N-1:0]    o_start_s;
  logic [N*DW-1:0] i_data_out_s;
  logic [N-1:0]    i_int_s;

  int n_cmp = 0;
  int n_bad = 0;

  aip_slave_hub #(
    .N_SLAVES   (N),
    .DATA_WIDTH (DW),
    .CONF_WIDTH (CW),
    .TO_CYCLES  (16)
  ) dut (
    .clk          (clk),
    .rst_a_n      (rst_a_n),
    .i_data_in    (i_data_in),
    .o_data_out   (o_data_out),
    .i_conf       (i_conf),
    .i_write      (i_write),
    .i_read       (i_read),
    .i_start      (i_start),
    .o_int_req    (o_int_req),
    .o_data_in_s  (o_data_in_s),
    .o_conf_s     (o_conf_s),
    .o_write_s    (o_write_s),
    .o_read_s     (o_read_s),
    .o_start_s    (o_start_s),
    .i_data_out_s (i_data_out_s),
    .i_int_s      (i_int_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Bus tasks start just after a negedge and consume exactly one rising edge.
  task automatic wr(input logic [CW-1:0] conf, input logic [DW-1:0] data);
    i_conf    = conf;
    i_data_in = data;
    i_write   = 1'b1;
    @(negedge clk);
    i_write   = 1'b0;
  endtask

  task automatic rd(input logic [CW-1:0] conf, output logic [DW-1:0] data);
    i_conf = conf;
    i_read = 1'b1;
    @(negedge clk);
    data   = o_data_out;
    i_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    rst_a_n   = 1'b0;
    i_data_in = '0;
    i_conf    = '0;
    i_write   = 1'b0;
    i_read    = 1'b0;
    i_start   = 1'b0;
    i_int_s   = '0;
    for (int k = 0; k < N; k++)
      i_data_out_s[k*DW +: DW] = 32'h5A00_0000 | 32'(k);

    // 1: reset values, then async reset while slave 1 is busy
    #1;
    check("rst_data_out", o_data_out, 32'h0);
    check("rst_int_req", 32'(o_int_req), 32'h0);
    check("rst_strobes", {20'h0, o_write_s, o_read_s, o_start_s}, 32'h0);
    @(negedge clk);
    rst_a_n = 1'b1;
    idle(1);
    wr(C_SEL, 32'h1);
    i_conf  = 5'h00;
    i_start = 1'b1;
    #1 check("start_s1", 32'(o_start_s), 32'h2);
    @(negedge clk);
    i_start = 1'b0;
    rd(C_STATUS, d);
    check("status_busy1", d, 32'h0001_0402);
    #2 rst_a_n = 1'b0;
    #1;
    check("async_rst_data_out", o_data_out, 32'h0);
    check("async_rst_int_req", 32'(o_int_req), 32'h0);
    @(negedge clk);
    rst_a_n = 1'b1;
    rd(C_STATUS, d);
    check("status_after_rst", d, 32'h0000_0400);

    // 2: forward write/read to slave 2
    wr(C_SEL, 32'h2);
    i_conf    = 5'h03;
    i_data_in = 32'hA5A5_A5A5;
    i_write   = 1'b1;
    #1;
    check("fwd_write_s", 32'(o_write_s), 32'h4);
    check("fwd_data_s2", o_data_in_s[2*DW +: DW], 32'hA5A5_A5A5);
    check("fwd_conf_s2", 32'(o_conf_s[2*CW +: CW]), 32'h3);
    @(negedge clk);
    i_write = 1'b0;
    i_read  = 1'b1;
    #1;
    check("fwd_read_s", 32'(o_read_s), 32'h4);
    check("rd_before_edge", o_data_out, 32'h0000_0400);
    @(negedge clk);
    i_read = 1'b0;
    check("rd_slave2", o_data_out, 32'h5A00_0002);
    idle(2);
    check("rd_hold", o_data_out, 32'h5A00_0002);

    // 3: out-of-range select sets error, strobes no slave; STATUS write clears it
    i_conf    = C_SEL;
    i_data_in = 32'h7;
    i_write   = 1'b1;
    #1 check("hub_no_strobe", 32'(o_write_s), 32'h0);
    @(negedge clk);
    i_write = 1'b0;
    rd(C_STATUS, d);
    check("status_err", d, 32'h0012_0400);
    wr(C_STATUS, 32'h0);
    rd(C_STATUS, d);
    check("status_err_clr", d, 32'h0002_0400);

    // 4: mask, edge-latched pending, set-wins-over-W1C
    wr(C_MASK, 32'h5);
    i_int_s = 4'b0011;
    idle(2);
    check("int_req_set", 32'(o_int_req), 32'h1);
    rd(C_PEND, d);
    check("pend_0011", d, 32'h3);
    i_int_s = 4'b0000;
    idle(1);
    i_int_s = 4'b0001;
    wr(C_PEND, 32'h1);
    rd(C_PEND, d);
    check("pend_set_wins", d, 32'h3);
    wr(C_PEND, 32'h1);
    idle(1);
    check("int_req_clr", 32'(o_int_req), 32'h0);
    rd(C_PEND, d);
    check("pend_w1c", d, 32'h2);
    wr(C_PEND, 32'h2);
    i_int_s = 4'b0000;

    // 5: watchdog on slave 3 (no interrupt ever arrives)
    wr(C_SEL, 32'h3);
    i_conf  = 5'h00;
    i_start = 1'b1;
    #1 check("start_s3", 32'(o_start_s), 32'h8);
    @(negedge clk);
    i_start = 1'b0;
    idle(15);
    rd(C_STATUS, d);
    check("to_pre_expiry", d, 32'h0003_0408);
    rd(C_PEND, d);
`ifdef AIP_HUB_TIMEOUT_EN
    check("to_pend", d, 32'h8);
    rd(C_STATUS, d);
    check("to_status", d, 32'h0023_0400);
    wr(C_PEND, 32'h8);
    rd(C_STATUS, d);
    check("to_flag_clr", d, 32'h0003_0400);
`else
    check("no_to_pend", d, 32'h0);
    rd(C_STATUS, d);
    check("no_to_status", d, 32'h0003_0408);
`endif

    // 6: start and select write in the same cycle -> start goes to old select
    wr(C_SEL, 32'h0);
    i_conf    = C_SEL;
    i_data_in = 32'h1;
    i_write   = 1'b1;
    i_start   = 1'b1;
    #1;
    check("start_old_sel", 32'(o_start_s), 32'h1);
    @(negedge clk);
    i_write = 1'b0;
    i_start = 1'b0;
    rd(C_STATUS, d);
`ifdef AIP_HUB_TIMEOUT_EN
    check("sel_after_start", d, 32'h0001_0401);
`else
    check("sel_after_start", d, 32'h0001_0409);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
